// File: rtl/config_loader_pkg.sv
// Shared types and helpers for the serial configuration-chain loader.
// The CRC helpers are used only when CONFIG_READBACK_EN is defined.
package config_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FETCH  = 3'd2,
        SHIFT  = 3'd3,
        VERIFY = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic int unsigned nwords(input int unsigned nweights, input int unsigned word_w);
        return (nweights + word_w - 1) / word_w;
    endfunction

    // Number of image bits carried by the first (partial) word.
    function automatic int unsigned firstBits(input int unsigned nweights, input int unsigned word_w);
        return nweights - (nwords(nweights, word_w) - 1) * word_w;
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/config_loader_clk_div.sv
// Chain clock generator: each bit period is CLK_DIV low cycles then CLK_DIV high cycles.
// fall_c marks the last high cycle, which is also the configOut sample point.
module config_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic clk_out,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] HALF    = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Counter parks at zero whenever the loader is not shifting, so a bit always starts low.
    always_comb begin
        cnt_next = '0;
        if (run && (cnt != LAST)) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            clk_out <= (cnt_next >= HALF);
        end
    end

    assign rise_c = run && (cnt == RISE_AT);
    assign fall_c = run && (cnt == LAST);

endmodule

// File: rtl/config_loader.sv
// Serial configuration-chain master: takes image words and shifts NWEIGHTS bits into the chain.
// Optional readback/CRC verification pass is enabled by defining CONFIG_READBACK_EN.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int unsigned NWEIGHTS = 5775,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic              sysClk,
    input  logic              sysRst,
    input  logic              start,
    input  logic [WORD_W-1:0] wordData,
    input  logic              wordValid,
    output logic              wordReady,
    output logic              configClk,
    output logic              configIn,
    output logic              configRst,
    input  logic              configOut,
    output logic              busy,
    output logic              done,
    output logic              crcErr
);

    localparam int unsigned NWORDS = nwords(NWEIGHTS, WORD_W);
    localparam int unsigned R      = firstBits(NWEIGHTS, WORD_W);
    localparam int unsigned BIT_W  = $clog2(NWEIGHTS + 1);
    localparam int unsigned WCNT_W = $clog2(NWORDS + 1);
    localparam int unsigned WBIT_W = $clog2(WORD_W + 1);
    localparam int unsigned CLR_W  = $clog2(2 * CLK_DIV);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NWEIGHTS);

    state_t              state, state_next;
    logic [WORD_W-1:0]   shift_word, shift_next;
    logic [WBIT_W-1:0]   wbits, wbits_next;
    logic [BIT_W-1:0]    bit_cnt, bit_next;
    logic [WCNT_W-1:0]   word_cnt, word_next;
    logic [CLR_W-1:0]    clr_cnt, clr_next;
    logic                in_next, rst_next, ready_next, busy_next, done_next, err_next;
    logic                run_c, rise_c, fall_c, clk_div_out;

`ifdef CONFIG_READBACK_EN
    logic [15:0] crc_tx, crc_tx_next;
    logic [15:0] crc_rx, crc_rx_next;
`else
    logic unused_config_out;
    assign unused_config_out = configOut;
`endif

    assign run_c     = (state == SHIFT) || (state == VERIFY);
    assign configClk = clk_div_out;

    config_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk     (sysClk),
        .rst     (sysRst),
        .run     (run_c),
        .clk_out (clk_div_out),
        .rise_c  (rise_c),
        .fall_c  (fall_c)
    );

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_next = state;
        shift_next = shift_word;
        wbits_next = wbits;
        bit_next   = bit_cnt;
        word_next  = word_cnt;
        clr_next   = clr_cnt;
        in_next    = configIn;
        err_next   = crcErr;
`ifdef CONFIG_READBACK_EN
        crc_tx_next = crc_tx;
        crc_rx_next = crc_rx;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                    clr_next   = '0;
                    bit_next   = '0;
                    word_next  = '0;
                    err_next   = 1'b0;
`ifdef CONFIG_READBACK_EN
                    crc_tx_next = CRC16_INIT;
                    crc_rx_next = CRC16_INIT;
`endif
                end
            end
            CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_next = FETCH;
                end else begin
                    clr_next = clr_cnt + CLR_W'(1);
                end
            end
            FETCH: begin
                if (wordValid && wordReady) begin
                    state_next = SHIFT;
                    word_next  = word_cnt + WCNT_W'(1);
                    // First word is left-aligned so its top used bit leads.
                    if (word_cnt == '0) begin
                        shift_next = wordData << (WORD_W - R);
                        wbits_next = WBIT_W'(R);
                    end else begin
                        shift_next = wordData;
                        wbits_next = WBIT_W'(WORD_W);
                    end
                    in_next = shift_next[WORD_W-1];
                end
            end
            SHIFT: begin
                if (rise_c) begin
                    bit_next = bit_cnt + BIT_W'(1);
`ifdef CONFIG_READBACK_EN
                    crc_tx_next = crc16_step(crc_tx, configIn);
`endif
                end
                if (fall_c) begin
                    if (bit_cnt == BIT_LAST) begin
`ifdef CONFIG_READBACK_EN
                        state_next = VERIFY;
                        bit_next   = '0;
                        in_next    = configOut;
`else
                        state_next = DONE;
`endif
                    end else if (wbits == WBIT_W'(1)) begin
                        state_next = FETCH;
                    end else begin
                        shift_next = shift_word << 1;
                        wbits_next = wbits - WBIT_W'(1);
                        in_next    = shift_word[WORD_W-2];
                    end
                end
            end
`ifdef CONFIG_READBACK_EN
            VERIFY: begin
                // Recirculate: the bit leaving the chain re-enters it, so content is preserved.
                if (rise_c) begin
                    bit_next    = bit_cnt + BIT_W'(1);
                    crc_rx_next = crc16_step(crc_rx, configIn);
                end
                if (fall_c) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_next = DONE;
                        err_next   = (crc_rx != crc_tx);
                    end else begin
                        in_next = configOut;
                    end
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        rst_next   = (state_next != CLEAR);
        ready_next = (state_next == FETCH);
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
    end

    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            state      <= IDLE;
            shift_word <= '0;
            wbits      <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            clr_cnt    <= '0;
            configIn   <= 1'b0;
            configRst  <= 1'b0;
            wordReady  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            crcErr     <= 1'b0;
        end else begin
            state      <= state_next;
            shift_word <= shift_next;
            wbits      <= wbits_next;
            bit_cnt    <= bit_next;
            word_cnt   <= word_next;
            clr_cnt    <= clr_next;
            configIn   <= in_next;
            configRst  <= rst_next;
            wordReady  <= ready_next;
            busy       <= busy_next;
            done       <= done_next;
            crcErr     <= err_next;
        end
    end

`ifdef CONFIG_READBACK_EN
    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            crc_tx <= CRC16_INIT;
            crc_rx <= CRC16_INIT;
        end else begin
            crc_tx <= crc_tx_next;
            crc_rx <= crc_rx_next;
        end
    end
`endif

endmodule
